// File: rtl/pico_core_if.sv
// -----------------------------------------------------------------------------
// pico_core_if -- instruction fetch channel between pico_core and program memory.
//
// Handshake: the core raises instr_req and holds it, together with a stable
// instr_addr, until a cycle in which instr_valid is also high. That cycle is
// the single transfer cycle and instr_data is captured on its closing rising
// edge. instr_valid while instr_req is low carries no meaning and is ignored.
// A request is never withdrawn before it has been accepted.
//
// Signals:
//   instr_req    core -> mem   fetch request
//   instr_addr   core -> mem   fetch address (PROG_ADDR_WIDTH)
//   instr_valid  mem  -> core  instr_data is valid this cycle
//   instr_data   mem  -> core  instruction word (INSTR_WIDTH)
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface pico_core_if #(
   parameter int PROG_ADDR_WIDTH = 6,
   parameter int INSTR_WIDTH     = 15
);
   logic                       instr_req;
   logic [PROG_ADDR_WIDTH-1:0] instr_addr;
   logic                       instr_valid;
   logic [INSTR_WIDTH-1:0]     instr_data;

   modport master (
      output instr_req,
      output instr_addr,
      input  instr_valid,
      input  instr_data
   );

   modport slave (
      input  instr_req,
      input  instr_addr,
      output instr_valid,
      output instr_data
   );
endinterface

// File: rtl/pico_core.sv
// -----------------------------------------------------------------------------
// pico_core -- parametrised single-issue SUBLEQ/MULTI processor core.
//
// Fetches one instruction at a time over the pico_core_if channel, executes
// it in a FETCH/EXEC/HALT state machine and stops when a taken SUBLEQ branch
// targets its own address. Register 0 is memory-mapped I/O: reads return
// in_port, writes land in out_port.
//
// Instruction word, MSB first: op | r1 | r2 | field
//   op=0 SUBLEQ : r2 <= r2 - r1; branch to field[PROG_ADDR_WIDTH-1:0] if <= 0
//   op=1 MULTI  : r2 <= (r1 * imm) >>> (IMM_WIDTH-1), imm = field[IMM_WIDTH-1:0]
//                 imm is signed Q1.(IMM_WIDTH-1); IMM_WIDTH must be >= 2
//
// Build option: define PICO_SAT_EN to saturate SUBLEQ and MULTI results to the
// signed DATA_WIDTH range instead of wrapping.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   run        in   1 = fetches may be issued
//   bus        if   pico_core_if.master fetch channel
//   in_port    in   value read from register 0
//   out_port   out  last value written to register 0
//   retired    out  one-cycle pulse per executed instruction
//   halted     out  core stopped on a self-branch
//   dbg_state  out  current FSM state (0 FETCH, 1 EXEC, 2 HALT)
// -----------------------------------------------------------------------------
module pico_core #(
   parameter int DATA_WIDTH      = 8,
   parameter int REG_ADDR_WIDTH  = 3,
   parameter int PROG_ADDR_WIDTH = 6,
   parameter int IMM_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   pico_core_if.master           bus,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  retired,
   output logic                  halted,
   output logic [1:0]            dbg_state
);

   localparam int FIELD_WIDTH = (PROG_ADDR_WIDTH > IMM_WIDTH) ? PROG_ADDR_WIDTH : IMM_WIDTH;
   localparam int INSTR_WIDTH = 1 + 2 * REG_ADDR_WIDTH + FIELD_WIDTH;
   localparam int NUM_REGS    = 2 ** REG_ADDR_WIDTH;
   localparam int PROD_WIDTH  = DATA_WIDTH + IMM_WIDTH;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                     state;
   logic [PROG_ADDR_WIDTH-1:0] pc;
   logic [INSTR_WIDTH-1:0]     ir;
   logic [DATA_WIDTH-1:0]      regs [NUM_REGS];

   // ---------------- decode ----------------
   logic                       op;
   logic [REG_ADDR_WIDTH-1:0]  r1;
   logic [REG_ADDR_WIDTH-1:0]  r2;
   logic [FIELD_WIDTH-1:0]     field;
   logic [PROG_ADDR_WIDTH-1:0] target;
   logic [IMM_WIDTH-1:0]       imm;

   assign op     = ir[INSTR_WIDTH-1];
   assign r1     = ir[INSTR_WIDTH-2 -: REG_ADDR_WIDTH];
   assign r2     = ir[INSTR_WIDTH-2-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
   assign field  = ir[FIELD_WIDTH-1:0];
   assign target = field[PROG_ADDR_WIDTH-1:0];
   assign imm    = field[IMM_WIDTH-1:0];

   // Register 0 is not storage: any read of it returns in_port.
   logic [DATA_WIDTH-1:0] opa;
   logic [DATA_WIDTH-1:0] opb;

   assign opa = (r1 == '0) ? in_port : regs[r1];
   assign opb = (r2 == '0) ? in_port : regs[r2];

   // ---------------- SUBLEQ datapath ----------------
   // One extra bit keeps the true difference so overflow is visible.
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] sub_res;

   assign diff = {opb[DATA_WIDTH-1], opb} - {opa[DATA_WIDTH-1], opa};

   // ---------------- MULTI datapath ----------------
   // Both operands are sign-extended to the full product width, so the
   // truncated product is exact. Dropping IMM_WIDTH-1 low bits is an
   // arithmetic shift that rounds toward minus infinity.
   logic signed [DATA_WIDTH-1:0] opa_s;
   logic signed [IMM_WIDTH-1:0]  imm_s;
   logic signed [PROD_WIDTH-1:0] opa_ext;
   logic signed [PROD_WIDTH-1:0] imm_ext;
   logic signed [PROD_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0]        mul_res;

   assign opa_s   = opa;
   assign imm_s   = imm;
   assign opa_ext = PROD_WIDTH'(opa_s);
   assign imm_ext = PROD_WIDTH'(imm_s);
   assign prod    = opa_ext * imm_ext;

`ifdef PICO_SAT_EN
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Overflow when the bit above the kept field disagrees with its sign bit;
   // the true sign picks the rail, so the branch test keeps the correct sign.
   logic sub_ovf;
   logic mul_ovf;

   assign sub_ovf = diff[DATA_WIDTH] ^ diff[DATA_WIDTH-1];
   assign mul_ovf = prod[PROD_WIDTH-1] ^ prod[PROD_WIDTH-2];

   assign sub_res = !sub_ovf ? diff[DATA_WIDTH-1:0]
                  : (diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX);
   assign mul_res = !mul_ovf ? prod[PROD_WIDTH-2 -: DATA_WIDTH]
                  : (prod[PROD_WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
   assign sub_res = diff[DATA_WIDTH-1:0];
   assign mul_res = prod[PROD_WIDTH-2 -: DATA_WIDTH];
`endif

   // Product fraction bits and the top guard bits are not needed in every
   // build; fold them here so they are visibly consumed.
   logic unused_bits;
   assign unused_bits = ^{prod[IMM_WIDTH-2:0], prod[PROD_WIDTH-1], diff[DATA_WIDTH]};

   // ---------------- result / next pc ----------------
   logic [DATA_WIDTH-1:0]      res;
   logic                       take;
   logic                       halt_hit;
   logic [PROG_ADDR_WIDTH-1:0] next_pc;

   assign res      = op ? mul_res : sub_res;
   assign take     = !op && (sub_res[DATA_WIDTH-1] || (sub_res == '0));
   assign halt_hit = take && (target == pc);
   assign next_pc  = take ? target : pc + 1'b1;

   assign bus.instr_addr = pc;
   assign dbg_state      = state;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_FETCH;
         pc            <= '0;
         ir            <= '0;
         out_port      <= '0;
         bus.instr_req <= 1'b0;
         retired       <= 1'b0;
         halted        <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         retired <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (bus.instr_req && bus.instr_valid) begin
                  ir            <= bus.instr_data;
                  bus.instr_req <= 1'b0;
                  state         <= ST_EXEC;
               end else begin
                  // A raised request stays up even if run drops meanwhile.
                  bus.instr_req <= bus.instr_req | run;
               end
            end
            ST_EXEC: begin
               retired <= 1'b1;
               if (r2 == '0) begin
                  out_port <= res;
               end else begin
                  regs[r2] <= res;
               end
               if (halt_hit) begin
                  halted        <= 1'b1;
                  bus.instr_req <= 1'b0;
                  state         <= ST_HALT;
               end else begin
                  pc            <= next_pc;
                  bus.instr_req <= run;
                  state         <= ST_FETCH;
               end
            end
            ST_HALT: begin
               halted        <= 1'b1;
               bus.instr_req <= 1'b0;
            end
            default: begin
               state         <= ST_FETCH;
               bus.instr_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
